// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage sitting directly in front of a combinational
//   instruction memory. Holds the PC, presents the word address to the
//   memory, and registers the returned word plus its PC into a single
//   output slot handed to decode over a valid/ready handshake. Branch/jump
//   redirects flush the slot; an all-zero word halts fetch; an
//   out-of-range or misaligned PC puts the unit into a sticky fault that
//   only reset clears.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   imem_addr       word index into instruction memory (pc[ADDR_W+1:2])
//   imem_instr      instruction word returned in the same cycle
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     byte target of the redirect
//   ready_i         decode accepts the output slot
//   valid_o         output slot holds an instruction
//   instr_o         registered instruction
//   pc_o            byte PC of instr_o
//   halted_o        fetch stopped on an all-zero word
//   fault_o         fetch stopped on a bad PC
//   fetch_cnt_o     number of accepted handshakes (wraps)
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned IMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_instr,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [31:0]       instr_o,
   output logic [31:0]       pc_o,
   output logic              halted_o,
   output logic              fault_o,
   output logic [15:0]       fetch_cnt_o
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WIDX_W = 30;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_HALT  = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [31:0]       pc;
   logic [31:0]       pc_next;
   logic              valid_next;
   logic [31:0]       instr_next;
   logic [31:0]       pc_o_next;
   logic [CNT_W-1:0]  cnt_next;

   logic              accept_c;
   logic              load_c;
   logic              in_range_c;
   logic              zero_word_c;
   logic              misaligned_c;

   // Memory address is a plain truncation of the byte PC.
   assign imem_addr = pc[ADDR_W+1:2];

   // Handshake and fetch-qualification terms.
   assign accept_c     = valid_o && ready_i;
   assign load_c       = (state == S_RUN) && (!valid_o || ready_i);
   // Range check uses the full word index, not the truncated address.
   assign in_range_c   = pc[31:2] < WIDX_W'(IMEM_DEPTH);
   assign zero_word_c  = (imem_instr == 32'h0000_0000);
   assign misaligned_c = (redirect_pc[1:0] != 2'b00);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath decisions, highest priority first.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      valid_next = valid_o;
      instr_next = instr_o;
      pc_o_next  = pc_o;
      cnt_next   = fetch_cnt_o + CNT_W'(accept_c);

      if (state == S_FAULT) begin
         // Sticky: only the handshake side keeps moving.
         if (accept_c) begin
            valid_next = 1'b0;
         end
      end else if (redirect_valid) begin
         // Flush the slot regardless of acceptance; no fetch this edge.
         valid_next = 1'b0;
         if (misaligned_c) begin
            state_next = S_FAULT;
            pc_next    = {redirect_pc[31:2], 2'b00};
         end else begin
            state_next = S_RUN;
            pc_next    = redirect_pc;
         end
      end else if (load_c) begin
         if (!in_range_c) begin
            state_next = S_FAULT;
            valid_next = 1'b0;
         end else if (zero_word_c) begin
            // PC stays on the zero word so a later redirect restarts cleanly.
            state_next = S_HALT;
            valid_next = 1'b0;
         end else begin
            instr_next = imem_instr;
            pc_o_next  = pc;
            valid_next = 1'b1;
            pc_next    = pc + 32'd4;
         end
      end else if (state == S_HALT) begin
         if (accept_c) begin
            valid_next = 1'b0;
         end
      end
   end

   // Output slot, PC and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         valid_o     <= 1'b0;
         instr_o     <= NOP;
         pc_o        <= 32'h0000_0000;
         halted_o    <= 1'b0;
         fault_o     <= 1'b0;
         fetch_cnt_o <= '0;
      end else begin
         pc          <= pc_next;
         valid_o     <= valid_next;
         instr_o     <= instr_next;
         pc_o        <= pc_o_next;
         halted_o    <= (state_next == S_HALT);
         fault_o     <= (state_next == S_FAULT);
         fetch_cnt_o <= cnt_next;
      end
   end

endmodule
